load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-side memory access engine of the MIPS core.
- The core hands it an opcode, a 32-bit effective address and register operands. It runs one bus transaction on the Avalon-style data port, honouring waitrequest.
- For stores, it aligns the data and byte-enables into the correct byte lanes.
- For loads, it extracts, merges and sign/zero-extends the returned lanes into a 32-bit register value.
- It is the consumer of the signed address immediates produced in decode.

Parameters:
- ADDR_W, 32, width of effective and bus addresses.
- DATA_W, 32, data bus width; the unit is only defined for 32.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request strobe; sampled only in IDLE.
- opcode  in  6  one of OPCODE_LB/LH/LWL/LW/LBU/LHU/LWR/SB/SH/SW.
- eff_addr  in  32  byte address (base + sign-extended immediate).
- rt_data  in  32  store data for stores; old rt value for LWL/LWR merge.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result or store completes.
- load_result  out  32  extended/merged load value; held until next start.
- misaligned  out  1  one-cycle pulse together with done when the access was rejected.
- data_address  out  32  word-aligned bus address, {eff_addr[31:2], 2'b00}.
- data_read  out  1  Avalon read request.
- data_write  out  1  Avalon write request.
- data_byteenable  out  4  active byte lanes; lane i = data[8i+7:8i].
- data_writedata  out  32  lane-aligned store data.
- data_waitrequest  in  1  slave stall.
- data_readdata  in  32  read data; valid in the cycle data_read=1 and data_waitrequest=0.

Behaviour:
- Reset (async, immediate): state IDLE, all outputs 0 (load_result=0, data_* = 0, busy=done=misaligned=0).
- Reset mid-transaction aborts it; no done is issued.
- FSM states: IDLE, ACCESS, FINISH.
- IDLE -> ACCESS on start with a legal aligned access:
  - Register opcode, eff_addr and rt_data.
  - Drive data_address, data_byteenable and data_writedata.
  - Assert data_read (loads) or data_write (stores) from the next cycle.
- IDLE -> FINISH on start with a misaligned access. Misaligned means: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. In this case:
  - No bus cycle.
  - misaligned and done pulse in FINISH.
  - load_result unchanged.
- ACCESS:
  - Request held stable while data_waitrequest=1.
  - The cycle it is 0: for loads, latch the processed data_readdata into load_result; go to FINISH; drop the request the following cycle.
- FINISH: done=1 for one cycle, then IDLE. busy=0 in FINISH.
- start while busy: ignored. start in the same cycle done=1: ignored.
- Minimum latency: start at cycle N -> request at N+1 -> done at N+2 with zero wait states. Each wait-state cycle adds one.
- Byte lanes are little-endian; n = eff_addr[1:0].
- Stores:
  - SB: byteenable = 1<<n; writedata = rt_data[7:0] replicated in all lanes.
  - SH: byteenable = 4'b0011<<n; writedata = rt_data[15:0] replicated in both halves.
  - SW: byteenable = 4'b1111.
- Loads:
  - LB/LBU: lane n, sign/zero-extended.
  - LH/LHU: lanes n+1:n, sign/zero-extended.
  - LW: full word.
  - LWL/LWR read all 4 lanes; misalignment is never flagged for them.
  - LWL: result = {mem[8(n+1)-1:0], rt[31-8(n+1):0]}; n=3 is the full word.
  - LWR: result = {rt[31:32-8n], mem[31:8n]}; n=0 is the full word.
  - Lanes not selected are don't-care on the bus and masked in result.
- Unknown opcode on start: treated as misaligned (error pulse, no bus cycle).

Optional Feature:
- LSU_BUS_TIMEOUT_EN: when defined, a 16-bit counter runs in ACCESS.
- If waitrequest stays high for 65535 consecutive cycles, the unit:
  - drops the request;
  - pulses done with misaligned=1;
  - leaves load_result unchanged.
- When undefined, the unit waits indefinitely; no counter is synthesised.

Decomposition:
- Opcode constants OPCODE_* and an lsu_state_t enum (IDLE/ACCESS/FINISH) live in package.v.
- One natural combinational sub-module, load_extract, maps (opcode, n, readdata, rt_data) -> load_result.
- Store lane formatting stays inline.

Test Plan:
- LB at addr 0x1003, readdata 0x80AABBCC, no wait -> load_result 0xFFFFFF80; LBU -> 0x00000080; done at start+2; byteenable 4'b1000.
- SH at 0x2002, rt_data 0x1234ABCD, waitrequest high 3 cycles -> write held stable 4 cycles; byteenable 4'b1100; writedata 0xABCDABCD; done at start+5.
- LH at 0x0001 -> no data_read ever asserted; misaligned=done=1 at start+1; load_result unchanged.
- LWL n=1 and LWR n=1, mem 0x44332211, rt 0xAABBCCDD -> LWL 0x2211CCDD; LWR 0xAA443322.
- Reset asserted while ACCESS with waitrequest high -> data_read drops asynchronously; no done; next start proceeds normally.
- Start pulsed on the done cycle, and while busy -> ignored; exactly one bus transaction per accepted start.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared opcode constants, FSM state type and access-legality helpers for the
// data-side load/store unit.
package load_store_unit_pkg;

  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LWL = 6'h22;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_LWR = 6'h26;
  localparam logic [5:0] OPCODE_SB  = 6'h28;
  localparam logic [5:0] OPCODE_SH  = 6'h29;
  localparam logic [5:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FINISH = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OPCODE_LB, OPCODE_LH, OPCODE_LWL, OPCODE_LW,
      OPCODE_LBU, OPCODE_LHU, OPCODE_LWR: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OPCODE_SB, OPCODE_SH, OPCODE_SW: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // Unknown opcodes are reported as illegal so they take the error path.
  function automatic logic access_ok(input logic [5:0] op, input logic [1:0] n);
    case (op)
      OPCODE_LB, OPCODE_LBU, OPCODE_SB,
      OPCODE_LWL, OPCODE_LWR:            return 1'b1;
      OPCODE_LH, OPCODE_LHU, OPCODE_SH:  return ~n[0];
      OPCODE_LW, OPCODE_SW:              return (n == 2'b00);
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extract.sv
// Combinational load formatter: selects, merges and extends returned byte lanes
// into the 32-bit register value.
module load_extract
  import load_store_unit_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  n_i,
  input  logic [31:0] readdata_i,
  input  logic [31:0] rt_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(readdata_i >> {n_i, 3'b000});
    half_sel = 16'(readdata_i >> {n_i, 3'b000});
    result_o = '0;
    case (opcode_i)
      OPCODE_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      OPCODE_LBU: result_o = {24'd0, byte_sel};
      OPCODE_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      OPCODE_LHU: result_o = {16'd0, half_sel};
      OPCODE_LW:  result_o = readdata_i;
      // LWL fills the upper bytes from memory, keeping the low bytes of rt.
      OPCODE_LWL: begin
        case (n_i)
          2'd0:    result_o = {readdata_i[7:0],  rt_i[23:0]};
          2'd1:    result_o = {readdata_i[15:0], rt_i[15:0]};
          2'd2:    result_o = {readdata_i[23:0], rt_i[7:0]};
          default: result_o = readdata_i;
        endcase
      end
      OPCODE_LWR: begin
        case (n_i)
          2'd0:    result_o = readdata_i;
          2'd1:    result_o = {rt_i[31:24], readdata_i[31:8]};
          2'd2:    result_o = {rt_i[31:16], readdata_i[31:16]};
          default: result_o = {rt_i[31:8],  readdata_i[31:24]};
        endcase
      end
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store engine: one Avalon transaction per accepted request.
// Define LSU_BUS_TIMEOUT_EN to abort accesses stalled for 65535 cycles.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] eff_addr,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_result,
  output logic              misaligned,
  output logic [ADDR_W-1:0] data_address,
  output logic              data_read,
  output logic              data_write,
  output logic [3:0]        data_byteenable,
  output logic [DATA_W-1:0] data_writedata,
  input  logic              data_waitrequest,
  input  logic [DATA_W-1:0] data_readdata
);

  lsu_state_t        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        n_q, n_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] extracted;
  logic              timeout;

  load_extract u_load_extract (
    .opcode_i   (op_q),
    .n_i        (n_q),
    .readdata_i (data_readdata),
    .rt_i       (rt_q),
    .result_o   (extracted)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // cnt_q counts stalled cycles already seen; this cycle is stall number cnt_q+1.
  always_comb begin
    cnt_d   = (state_q == ST_ACCESS && data_waitrequest) ? cnt_q + 16'd1 : 16'd0;
    timeout = (state_q == ST_ACCESS) && data_waitrequest && (cnt_q == 16'hFFFE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    n_d     = n_q;
    rt_d    = rt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (access_ok(opcode, eff_addr[1:0])) begin
            state_d = ST_ACCESS;
            err_d   = 1'b0;
            op_d    = opcode;
            n_d     = eff_addr[1:0];
            rt_d    = rt_data;
            addr_d  = {eff_addr[ADDR_W-1:2], 2'b00};
            rd_d    = is_load(opcode);
            wr_d    = is_store(opcode);
            case (opcode)
              OPCODE_LB, OPCODE_LBU, OPCODE_SB: be_d = 4'b0001 << eff_addr[1:0];
              OPCODE_LH, OPCODE_LHU, OPCODE_SH: be_d = 4'b0011 << eff_addr[1:0];
              default:                          be_d = 4'b1111;
            endcase
            case (opcode)
              OPCODE_SB: wd_d = {4{rt_data[7:0]}};
              OPCODE_SH: wd_d = {2{rt_data[15:0]}};
              OPCODE_SW: wd_d = rt_data;
              default:   wd_d = wd_q;
            endcase
          end else begin
            state_d = ST_FINISH;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (!data_waitrequest) begin
          if (rd_q) res_d = extracted;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_FINISH;
        end else if (timeout) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      n_q     <= '0;
      rt_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n_q     <= n_d;
      rt_q    <= rt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      res_q   <= res_d;
    end
  end

  assign busy            = (state_q == ST_ACCESS);
  assign done            = (state_q == ST_FINISH);
  assign misaligned      = (state_q == ST_FINISH) && err_q;
  assign load_result     = res_q;
  assign data_address    = addr_q;
  assign data_read       = rd_q;
  assign data_write      = wr_q;
  assign data_byteenable = be_q;
  assign data_writedata  = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// transactions checked against a byte-level reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] eff_addr, rt_data;
  logic        busy, done, misaligned;
  logic [31:0] load_result;
  logic [31:0] data_address;
  logic        data_read, data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic        data_waitrequest;
  logic [31:0] data_readdata;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_res = 32'd0;

  logic [5:0] ops [11] = '{OPCODE_LB, OPCODE_LH, OPCODE_LWL, OPCODE_LW, OPCODE_LBU,
                           OPCODE_LHU, OPCODE_LWR, OPCODE_SB, OPCODE_SH, OPCODE_SW, 6'h3F};

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .eff_addr(eff_addr),
    .rt_data(rt_data), .busy(busy), .done(done), .load_result(load_result),
    .misaligned(misaligned), .data_address(data_address), .data_read(data_read),
    .data_write(data_write), .data_byteenable(data_byteenable),
    .data_writedata(data_writedata), .data_waitrequest(data_waitrequest),
    .data_readdata(data_readdata)
  );

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [5:0] op);
    case (op)
      OPCODE_LB, OPCODE_LBU, OPCODE_SB:             return 1;
      OPCODE_LH, OPCODE_LHU, OPCODE_SH:             return 2;
      OPCODE_LW, OPCODE_SW, OPCODE_LWL, OPCODE_LWR: return 4;
      default:                                      return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [5:0] op, input logic [31:0] addr);
    int sz = op_size(op);
    if (op == OPCODE_LWL || op == OPCODE_LWR) return 1'b1;
    if (sz == 0) return 1'b0;
    return (addr % sz) == 0;
  endfunction

  function automatic bit m_is_ld(input logic [5:0] op);
    return op == OPCODE_LB || op == OPCODE_LH || op == OPCODE_LW || op == OPCODE_LBU ||
           op == OPCODE_LHU || op == OPCODE_LWL || op == OPCODE_LWR;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] addr);
    int n = int'(addr % 4);
    if (op_size(op) == 1) return 4'b0001 << n;
    if (op_size(op) == 2) return 4'b0011 << n;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] rt);
    if (op == OPCODE_SB) return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
    if (op == OPCODE_SH) return {rt[15:0], rt[15:0]};
    return rt;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] mem, input logic [31:0] rt);
    logic [7:0]  m [4];
    logic [7:0]  r [4];
    logic [7:0]  o [4];
    logic [15:0] h;
    int n = int'(addr % 4);
    for (int i = 0; i < 4; i++) begin
      m[i] = mem[8*i +: 8];
      r[i] = rt[8*i +: 8];
    end
    case (op)
      OPCODE_LB:  return {{24{m[n][7]}}, m[n]};
      OPCODE_LBU: return {24'd0, m[n]};
      OPCODE_LH:  begin h = {m[n+1], m[n]}; return {{16{h[15]}}, h}; end
      OPCODE_LHU: begin h = {m[n+1], m[n]}; return {16'd0, h}; end
      OPCODE_LW:  return mem;
      OPCODE_LWL: begin
        for (int j = 0; j < 4; j++) o[j] = (j >= 3 - n) ? m[j - (3 - n)] : r[j];
        return {o[3], o[2], o[1], o[0]};
      end
      OPCODE_LWR: begin
        for (int j = 0; j < 4; j++) o[j] = (j <= 3 - n) ? m[j + n] : r[j];
        return {o[3], o[2], o[1], o[0]};
      end
      default:    return 32'd0;
    endcase
  endfunction

  // ---------------- bus driver / observer ----------------
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] mem, input int waits,
                        output int done_at, output logic mis, output int req_cycles,
                        output logic rd, output logic wr, output logic [3:0] be,
                        output logic [31:0] wd, output logic [31:0] adr, output bit stable);
    int k = 0;
    @(negedge clk);
    start = 1'b1; opcode = op; eff_addr = addr; rt_data = rt;
    data_readdata = mem; data_waitrequest = 1'b0;
    done_at = -1; mis = 1'b0; req_cycles = 0; rd = 1'b0; wr = 1'b0;
    be = 4'd0; wd = 32'd0; adr = 32'd0; stable = 1'b1;
    while (done_at < 0 && k < 200) begin
      @(negedge clk);
      k++;
      start = 1'b0; opcode = 6'($urandom); eff_addr = $urandom; rt_data = $urandom;
      if (data_read || data_write) begin
        if (req_cycles == 0) begin
          rd = data_read; wr = data_write; be = data_byteenable;
          wd = data_writedata; adr = data_address;
        end else if ({data_read, data_write, data_byteenable, data_writedata, data_address}
                     !== {rd, wr, be, wd, adr}) begin
          stable = 1'b0;
        end
        req_cycles++;
        data_waitrequest = (req_cycles <= waits);
        data_readdata    = data_waitrequest ? $urandom : mem;
      end else begin
        data_waitrequest = 1'b0;
      end
      if (done) begin
        done_at = k;
        mis     = misaligned;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, misaligned, data_read, data_write, data_byteenable} !== 9'd0 ||
        load_result !== 32'd0 || data_address !== 32'd0 || data_writedata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b mis=%b rd=%b wr=%b be=%h res=%h addr=%h wd=%h, required all zero",
               busy, done, misaligned, data_read, data_write, data_byteenable, load_result,
               data_address, data_writedata);
    end
    reset = 1'b0;
    exp_res = 32'd0;
  endtask

  task automatic test_lb_lbu();
    int d, rq; logic mi, rd, wr; logic [3:0] be; logic [31:0] wd, adr; bit st;
    logic [5:0] op [2] = '{OPCODE_LB, OPCODE_LBU};
    logic [31:0] want [2] = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      run_op(op[i], 32'h1003, 32'h0, 32'h80AABBCC, 0, d, mi, rq, rd, wr, be, wd, adr, st);
      exp_res = want[i];
      vectors++;
      if (load_result !== want[i]) begin
        errors++; $display("FAIL lb_result[%0d]: got %h, required %h", i, load_result, want[i]);
      end
      vectors++;
      if (d !== 2 || be !== 4'b1000 || rd !== 1'b1 || mi !== 1'b0 || adr !== 32'h1000) begin
        errors++;
        $display("FAIL lb_bus[%0d]: done_at=%0d be=%b rd=%b mis=%b addr=%h, required 2 1000 1 0 00001000",
                 i, d, be, rd, mi, adr);
      end
    end
  endtask

  task automatic test_sh_wait();
    int d, rq; logic mi, rd, wr; logic [3:0] be; logic [31:0] wd, adr; bit st;
    run_op(OPCODE_SH, 32'h2002, 32'h1234ABCD, 32'h0, 3, d, mi, rq, rd, wr, be, wd, adr, st);
    vectors++;
    if (rq !== 4 || st !== 1'b1 || wr !== 1'b1 || rd !== 1'b0) begin
      errors++;
      $display("FAIL sh_hold: req_cycles=%0d stable=%0d wr=%b rd=%b, required 4 1 1 0", rq, st, wr, rd);
    end
    vectors++;
    if (be !== 4'b1100 || wd !== 32'hABCDABCD || d !== 5 || load_result !== exp_res) begin
      errors++;
      $display("FAIL sh_lanes: be=%b wd=%h done_at=%0d res=%h, required 1100 abcdabcd 5 %h",
               be, wd, d, load_result, exp_res);
    end
  endtask

  task automatic test_misaligned();
    int d, rq; logic mi, rd, wr; logic [3:0] be; logic [31:0] wd, adr; bit st;
    logic [5:0]  op [4] = '{OPCODE_LH, OPCODE_LHU, OPCODE_SW, 6'h3F};
    logic [31:0] ad [4] = '{32'h1, 32'h3, 32'h2, 32'h0};
    for (int i = 0; i < 4; i++) begin
      run_op(op[i], ad[i], 32'h5555AAAA, 32'h12345678, 0, d, mi, rq, rd, wr, be, wd, adr, st);
      vectors++;
      if (rq !== 0 || d !== 1 || mi !== 1'b1 || load_result !== exp_res) begin
        errors++;
        $display("FAIL misaligned[%0d]: req_cycles=%0d done_at=%0d mis=%b res=%h, required 0 1 1 %h",
                 i, rq, d, mi, load_result, exp_res);
      end
    end
  endtask

  task automatic test_lwl_lwr();
    int d, rq; logic mi, rd, wr; logic [3:0] be; logic [31:0] wd, adr; bit st;
    logic [5:0]  op   [2] = '{OPCODE_LWL, OPCODE_LWR};
    logic [31:0] want [2] = '{32'h2211CCDD, 32'hAA443322};
    for (int i = 0; i < 2; i++) begin
      run_op(op[i], 32'h301, 32'hAABBCCDD, 32'h44332211, 1, d, mi, rq, rd, wr, be, wd, adr, st);
      exp_res = want[i];
      vectors++;
      if (load_result !== want[i] || be !== 4'b1111 || d !== 3 || mi !== 1'b0) begin
        errors++;
        $display("FAIL lwl_lwr[%0d]: res=%h be=%b done_at=%0d mis=%b, required %h 1111 3 0",
                 i, load_result, be, d, mi, want[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int nd = 0; int d, rq; logic mi, rd, wr; logic [3:0] be; logic [31:0] wd, adr; bit st;
    @(negedge clk);
    start = 1'b1; opcode = OPCODE_LW; eff_addr = 32'h10; data_waitrequest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (data_read !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_req: rd=%b busy=%b, required 1 1", data_read, busy);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (data_read !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_async: rd=%b busy=%b, required 0 0", data_read, busy);
    end
    repeat (2) @(negedge clk) if (done) nd++;
    reset = 1'b0; data_waitrequest = 1'b0;
    repeat (3) @(negedge clk) if (done) nd++;
    exp_res = 32'd0;
    vectors++;
    if (nd !== 0 || load_result !== 32'd0) begin
      errors++; $display("FAIL abort_nodone: dones=%0d res=%h, required 0 00000000", nd, load_result);
    end
    run_op(OPCODE_LBU, 32'h42, 32'h0, 32'h00C30000, 0, d, mi, rq, rd, wr, be, wd, adr, st);
    exp_res = 32'h000000C3;
    vectors++;
    if (load_result !== exp_res || d !== 2 || rq !== 1) begin
      errors++;
      $display("FAIL abort_recover: res=%h done_at=%0d req=%0d, required %h 2 1", load_result, d, rq, exp_res);
    end
  endtask

  task automatic test_ignored_start();
    int reads = 0, writes = 0, dones = 0; logic b1 = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = OPCODE_LB; eff_addr = 32'h2001; rt_data = 32'h0;
    data_readdata = 32'h00007F00; data_waitrequest = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (data_read)  reads++;
      if (data_write) writes++;
      if (done)       dones++;
      if (k == 1)     b1 = busy;
      start = (k == 1 || k == 2); opcode = OPCODE_SW; eff_addr = 32'h40; rt_data = $urandom;
    end
    start = 1'b0;
    exp_res = 32'h0000007F;
    vectors++;
    if (reads !== 1 || writes !== 0 || dones !== 1 || b1 !== 1'b1 || load_result !== exp_res) begin
      errors++;
      $display("FAIL ignored_start: reads=%0d writes=%0d dones=%0d busy=%b res=%h, required 1 0 1 1 %h",
               reads, writes, dones, b1, load_result, exp_res);
    end
  endtask

  task automatic test_random();
    int d, rq, w; logic mi, rd, wr; logic [3:0] be; logic [31:0] wd, adr; bit st;
    logic [5:0] op; logic [31:0] a, rt, mem;
    bit ok;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 10)]; a = $urandom_range(0, 32'hFFFF) ; rt = $urandom;
      mem = $urandom; w = $urandom_range(0, 3);
      run_op(op, a, rt, mem, w, d, mi, rq, rd, wr, be, wd, adr, st);
      ok = m_legal(op, a);
      if (ok && m_is_ld(op)) exp_res = m_load(op, a, mem, rt);
      vectors++;
      if (ok) begin
        if (d !== w + 2 || rq !== w + 1 || mi !== 1'b0 || st !== 1'b1 || rd !== m_is_ld(op) ||
            wr !== !m_is_ld(op) || be !== m_be(op, a) || adr !== {a[31:2], 2'b00} ||
            (!m_is_ld(op) && wd !== m_wd(op, rt)) || load_result !== exp_res) begin
          errors++;
          $display("FAIL random[%0d] op=%h addr=%h: done_at=%0d req=%0d mis=%b st=%0d rd=%b wr=%b be=%b adr=%h wd=%h res=%h, required done_at=%0d be=%b wd=%h res=%h",
                   i, op, a, d, rq, mi, st, rd, wr, be, adr, wd, load_result, w + 2,
                   m_be(op, a), m_wd(op, rt), exp_res);
        end
      end else begin
        if (d !== 1 || rq !== 0 || mi !== 1'b1 || load_result !== exp_res) begin
          errors++;
          $display("FAIL random_err[%0d] op=%h addr=%h: done_at=%0d req=%0d mis=%b res=%h, required 1 0 1 %h",
                   i, op, a, d, rq, mi, load_result, exp_res);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 6'd0; eff_addr = 32'd0; rt_data = 32'd0;
    data_waitrequest = 1'b0; data_readdata = 32'd0;
    test_reset();
    test_lb_lbu();
    test_sh_wait();
    test_misaligned();
    test_lwl_lwr();
    test_reset_abort();
    test_ignored_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
